// File: rtl/parking_slot_ctrl_if.sv
// Bus between the parking gate controller and its entry/exit/display clients.
// master: gate side that raises requests; slave: the slot controller.
interface parking_slot_ctrl_if #(
    parameter int unsigned NSLOTS = 8
);
    logic              entry_req;
    logic              exit_req;
    logic [3:0]        exit_slot;
    logic              grant_valid;
    logic [3:0]        grant_slot;
    logic              exit_ack;
    logic              exit_err;
    logic              full;
    logic [NSLOTS-1:0] occupied;
    logic [3:0]        free_count;
    logic [3:0]        disp_code;

    modport master (
        output entry_req, exit_req, exit_slot,
        input  grant_valid, grant_slot, exit_ack, exit_err,
        input  full, occupied, free_count, disp_code
    );

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output grant_valid, grant_slot, exit_ack, exit_err,
        output full, occupied, free_count, disp_code
    );
endinterface

// File: rtl/parking_slot_ctrl.sv
// Parking slot occupancy controller: grants the lowest free slot on entry,
// releases a named slot on exit, and drives the slot-indicator code.
// Optional feature macro PARK_SCAN_EN: disp_code cycles through occupied
// slots every SCAN_DIV clocks while the lot is not full.
module parking_slot_ctrl #(
    parameter int unsigned NSLOTS   = 8,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    parking_slot_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, GRANT, RELEASE} state_t;

    localparam logic [3:0] FULL_CODE = 4'b1100;

    if (NSLOTS < 1 || NSLOTS > 8 || SCAN_DIV < 2) begin : g_param_check
        $error("parking_slot_ctrl: NSLOTS must be 1..8 and SCAN_DIV >= 2");
    end

    state_t            state, state_nxt;
    logic [NSLOTS-1:0] occupied, occupied_nxt;
    logic [3:0]        free_count, free_count_nxt;
    logic [3:0]        grant_slot, grant_slot_nxt;
    logic [3:0]        disp_code, disp_code_nxt;
    logic              grant_valid, grant_valid_nxt;
    logic              exit_ack, exit_ack_nxt;
    logic              exit_err, exit_err_nxt;
    logic              full, full_nxt;
    // Block flags: set after a grant/ack/err, cleared once the request drops.
    logic              entry_block, entry_block_nxt;
    logic              exit_block, exit_block_nxt;
    logic [3:0]        free_slot;
    logic              free_found;
    logic              slot_taken;

`ifdef PARK_SCAN_EN
    localparam int unsigned CW = $clog2(SCAN_DIV);

    logic [CW-1:0] scan_cnt;
    logic [3:0]    scan_ptr, scan_ptr_nxt;
    logic          scan_found;

    // Free-running scan divider and pointer; grants/releases never restart it.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_ptr <= '0;
        end else begin
            scan_cnt <= (scan_cnt == CW'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;
            scan_ptr <= scan_ptr_nxt;
        end
    end

    // On each divider tick, advance to the next occupied slot (ascending, wrapping).
    always_comb begin
        scan_ptr_nxt = scan_ptr;
        scan_found   = 1'b0;
        if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            for (int unsigned k = 1; k <= NSLOTS; k++) begin
                for (int unsigned j = 0; j < NSLOTS; j++) begin
                    if (!scan_found && occupied[j] && ((32'(scan_ptr) + k) % NSLOTS) == j) begin
                        scan_found   = 1'b1;
                        scan_ptr_nxt = 4'(j);
                    end
                end
            end
        end
    end
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            occupied    <= '0;
            free_count  <= 4'(NSLOTS);
            grant_slot  <= '0;
            disp_code   <= '0;
            grant_valid <= 1'b0;
            exit_ack    <= 1'b0;
            exit_err    <= 1'b0;
            full        <= 1'b0;
            entry_block <= 1'b0;
            exit_block  <= 1'b0;
        end else begin
            state       <= state_nxt;
            occupied    <= occupied_nxt;
            free_count  <= free_count_nxt;
            grant_slot  <= grant_slot_nxt;
            disp_code   <= disp_code_nxt;
            grant_valid <= grant_valid_nxt;
            exit_ack    <= exit_ack_nxt;
            exit_err    <= exit_err_nxt;
            full        <= full_nxt;
            entry_block <= entry_block_nxt;
            exit_block  <= exit_block_nxt;
        end
    end

    // Next-state, occupancy update and output pulses.
    always_comb begin
        state_nxt       = state;
        occupied_nxt    = occupied;
        free_count_nxt  = free_count;
        grant_slot_nxt  = grant_slot;
        grant_valid_nxt = 1'b0;
        exit_ack_nxt    = 1'b0;
        exit_err_nxt    = 1'b0;
        entry_block_nxt = entry_block;
        exit_block_nxt  = exit_block;
        free_slot       = '0;
        free_found      = 1'b0;
        slot_taken      = 1'b0;

        if (!bus.entry_req) entry_block_nxt = 1'b0;
        if (!bus.exit_req)  exit_block_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.exit_req && !exit_block)
                    state_nxt = RELEASE;
                else if (bus.entry_req && !entry_block && !full)
                    state_nxt = SEARCH;
            end
            SEARCH: begin
                for (int unsigned i = 0; i < NSLOTS; i++) begin
                    if (!free_found && !occupied[i]) begin
                        free_found = 1'b1;
                        free_slot  = 4'(i);
                    end
                end
                grant_slot_nxt = free_slot;
                state_nxt      = GRANT;
            end
            GRANT: begin
                for (int unsigned i = 0; i < NSLOTS; i++) begin
                    if (grant_slot == 4'(i)) occupied_nxt[i] = 1'b1;
                end
                if (free_count != 4'd0) free_count_nxt = free_count - 4'd1;
                grant_valid_nxt = 1'b1;
                entry_block_nxt = 1'b1;
                state_nxt       = IDLE;
            end
            RELEASE: begin
                for (int unsigned i = 0; i < NSLOTS; i++) begin
                    if (bus.exit_slot == 4'(i) && occupied[i]) slot_taken = 1'b1;
                end
                if (slot_taken) begin
                    for (int unsigned i = 0; i < NSLOTS; i++) begin
                        if (bus.exit_slot == 4'(i)) occupied_nxt[i] = 1'b0;
                    end
                    free_count_nxt = free_count + 4'd1;
                    exit_ack_nxt   = 1'b1;
                end else begin
                    exit_err_nxt = 1'b1;
                end
                exit_block_nxt = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        full_nxt = (free_count_nxt == 4'd0);

`ifdef PARK_SCAN_EN
        if (full_nxt)
            disp_code_nxt = FULL_CODE;
        else if (occupied_nxt == '0)
            disp_code_nxt = '0;
        else
            disp_code_nxt = scan_ptr_nxt;
`else
        // Leaving the full state restores the last granted slot, which is still held in grant_slot.
        disp_code_nxt = disp_code;
        if (full_nxt)
            disp_code_nxt = FULL_CODE;
        else if (state == GRANT || full)
            disp_code_nxt = grant_slot;
`endif
    end

    assign bus.grant_valid = grant_valid;
    assign bus.grant_slot  = grant_slot;
    assign bus.exit_ack    = exit_ack;
    assign bus.exit_err    = exit_err;
    assign bus.full        = full;
    assign bus.occupied    = occupied;
    assign bus.free_count  = free_count;
    assign bus.disp_code   = disp_code;
endmodule
